sumador: RTL and testbench
==========================

SUMADOR -- requirements
Module: sumador

Interface
REQ-001 The block SHALL take parameter WORD, default 32, giving the operand and result width in bits; legal values are multiples of 4, minimum 4.
REQ-002 The block SHALL take parameter REG_OUT, default 1, where 1 enables the registered outputs and 0 holds them at zero.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 The ports SHALL be as follows:
- clk_i   input   1      clock
- rst_i   input   1      asynchronous reset, active-high
- opea    input   WORD   operand a
- opeb    input   WORD   operand b
- cin     input   1      carry in
- sal     output  WORD   combinational sum
- cout    output  1      combinational carry out
- ovf     output  1      combinational signed overflow
- sal_q   output  WORD   registered sum
- cout_q  output  1      registered carry out
- ovf_q   output  1      registered signed overflow

Function
REQ-005 {cout, sal} SHALL equal opea + opeb + cin, computed at WORD+1 bits, with no truncation before the carry.
REQ-006 sal, cout and ovf SHALL be purely combinational, with zero-cycle latency from opea, opeb and cin, and no dependence on clk_i or rst_i.
REQ-007 ovf SHALL be 1 exactly when opea[WORD-1] equals opeb[WORD-1] and sal[WORD-1] differs from them.
REQ-008 The carry network SHALL be carry-lookahead: 4-bit groups generate group propagate and generate terms, and a second-level lookahead computes the inter-group carries.
REQ-009 The result SHALL be bit-exact for all operand values, including wrap-around: all-ones + 1 gives sal=0 and cout=1.
REQ-010 When REG_OUT=1, sal_q, cout_q and ovf_q SHALL capture sal, cout and ovf on every rising edge of clk_i, giving one cycle of latency, with no enable and no handshake.
REQ-011 When REG_OUT=0, sal_q, cout_q and ovf_q SHALL be constant 0.
REQ-012 cin SHALL be a normal operand bit; cin=0 makes the block a plain adder.

Reset
REQ-013 Asserting rst_i SHALL immediately force sal_q=0, cout_q=0 and ovf_q=0, without waiting for a clock edge.
REQ-014 While rst_i is high, the registered outputs SHALL remain 0 and the combinational outputs SHALL keep tracking the inputs.
REQ-015 After rst_i deasserts, the first rising edge of clk_i SHALL load the current combinational result.
REQ-016 Reset asserted mid-stream SHALL discard the held result, with no residual state.

Structure
REQ-017 One sub-module, sumador_cla4, SHALL implement the 4-bit lookahead group; it takes a[3:0], b[3:0] and ci, and produces s[3:0], group propagate pg and group generate gg.
REQ-018 sumador SHALL instantiate WORD/4 copies of sumador_cla4 through a generate loop, plus the second-level carry logic and the output register.
REQ-019 The default WORD width constant SHALL live in a shared package, sumador_pkg, which the ALU also uses; there are no typedefs.

Verification
REQ-020 With opea=0x00000005, opeb=0x00000003, cin=0: sal=0x00000008, cout=0, ovf=0, and sal_q=0x00000008 one clock later.
REQ-021 With opea=0xFFFFFFFF, opeb=0x00000001, cin=0: sal=0x00000000, cout=1, ovf=0.
REQ-022 With opea=0x7FFFFFFF, opeb=0x00000001, cin=0: sal=0x80000000, cout=0, ovf=1.
REQ-023 With opea=0xFFFFFFFF, opeb=0xFFFFFFFF, cin=1: sal=0xFFFFFFFF, cout=1, ovf=0.
REQ-024 With sal_q=0x00000008, asserting rst_i between clock edges SHALL give sal_q=0 before the next edge while sal stays 0x00000008.
REQ-025 A random sweep of 10,000 vectors SHALL match a WORD+1-bit reference sum every cycle, repeated with WORD=8 and WORD=64.

Source files
------------

// File: rtl/sumador_pkg.sv
// sumador_pkg: shared width constants for the adder and the ALU.
// WORD_DEF is the default datapath width; GRP is the lookahead group size.
package sumador_pkg;

    localparam int WORD_DEF = 32;
    localparam int GRP      = 4;

endpackage

// File: rtl/sumador_cla4.sv
// sumador_cla4: one 4-bit carry-lookahead group.
// Produces the group sum plus group propagate/generate for the next level.
module sumador_cla4
    import sumador_pkg::*;
(
    input  logic [GRP-1:0] a,
    input  logic [GRP-1:0] b,
    input  logic           ci,
    output logic [GRP-1:0] s,
    output logic           pg,
    output logic           gg
);

    logic [GRP-1:0] p;
    logic [GRP-1:0] g;
    logic [GRP-1:0] c;

    // Bit propagate/generate, flat in-group carries, sum and group terms
    always_comb begin
        p = a ^ b;
        g = a & b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0])
             | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        s  = p ^ c;
        pg = &p;
        gg = g[3] | (p[3] & g[2])
           | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
    end

endmodule

// File: rtl/sumador.sv
// sumador: WORD-bit two-level carry-lookahead adder with carry and
// signed overflow, plus an optional one-cycle output register.
module sumador
    import sumador_pkg::*;
#(
    parameter int WORD    = WORD_DEF,
    parameter bit REG_OUT = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [WORD-1:0] opea,
    input  logic [WORD-1:0] opeb,
    input  logic            cin,
    output logic [WORD-1:0] sal,
    output logic            cout,
    output logic            ovf,
    output logic [WORD-1:0] sal_q,
    output logic            cout_q,
    output logic            ovf_q
);

    localparam int NG = WORD / GRP;

    logic [NG-1:0] pg;
    logic [NG-1:0] gg;
    logic [NG:0]   carry;

    // Carry out of group k from groups 0..k and cin, as one flat
    // sum-of-products so every group carry is a single lookahead level.
    function automatic logic grp_carry(
        input logic [NG-1:0] g,
        input logic [NG-1:0] p,
        input logic          c0,
        input int            k
    );
        logic acc;
        logic run;
        acc = 1'b0;
        run = 1'b1;
        for (int j = NG - 1; j >= 0; j--) begin
            if (j <= k) begin
                acc = acc | (run & g[j]);
                run = run & p[j];
            end
        end
        return acc | (run & c0);
    endfunction

    assign carry[0] = cin;

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        sumador_cla4 u_cla4 (
            .a  (opea[gi*GRP +: GRP]),
            .b  (opeb[gi*GRP +: GRP]),
            .ci (carry[gi]),
            .s  (sal[gi*GRP +: GRP]),
            .pg (pg[gi]),
            .gg (gg[gi])
        );
        assign carry[gi+1] = grp_carry(gg, pg, cin, gi);
    end

    assign cout = carry[NG];
    assign ovf  = (opea[WORD-1] == opeb[WORD-1])
                & (sal[WORD-1] != opea[WORD-1]);

    if (REG_OUT) begin : g_reg
        // Capture the combinational result every edge; reset clears it
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                sal_q  <= '0;
                cout_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                sal_q  <= sal;
                cout_q <= cout;
                ovf_q  <= ovf;
            end
        end
    end else begin : g_noreg
        assign sal_q  = '0;
        assign cout_q = 1'b0;
        assign ovf_q  = 1'b0;
    end

endmodule

// File: tb/tb_sumador.sv
// tb_sumador: directed vectors, reset sequences and a random sweep
// at WORD = 8, 32 and 64, plus a REG_OUT = 0 instance.
module tb_sumador;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] a32, b32, s32, sq32, sz;
    logic        c32, co32, ov32, coq32, ovq32, coz, ovz;
    logic [7:0]  a8, b8, s8, sq8;
    logic        c8, co8, ov8, coq8, ovq8;
    logic [63:0] a64, b64, s64, sq64;
    logic        c64, co64, ov64, coq64, ovq64;

    sumador #(.WORD(32), .REG_OUT(1'b1)) dut32 (
        .clk_i(clk), .rst_i(rst), .opea(a32), .opeb(b32), .cin(c32),
        .sal(s32), .cout(co32), .ovf(ov32),
        .sal_q(sq32), .cout_q(coq32), .ovf_q(ovq32)
    );

    sumador #(.WORD(32), .REG_OUT(1'b0)) dutz (
        .clk_i(clk), .rst_i(rst), .opea(a32), .opeb(b32), .cin(c32),
        .sal(), .cout(), .ovf(),
        .sal_q(sz), .cout_q(coz), .ovf_q(ovz)
    );

    sumador #(.WORD(8), .REG_OUT(1'b1)) dut8 (
        .clk_i(clk), .rst_i(rst), .opea(a8), .opeb(b8), .cin(c8),
        .sal(s8), .cout(co8), .ovf(ov8),
        .sal_q(sq8), .cout_q(coq8), .ovf_q(ovq8)
    );

    sumador #(.WORD(64), .REG_OUT(1'b1)) dut64 (
        .clk_i(clk), .rst_i(rst), .opea(a64), .opeb(b64), .cin(c64),
        .sal(s64), .cout(co64), .ovf(ov64),
        .sal_q(sq64), .cout_q(coq64), .ovf_q(ovq64)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name,
                       input logic [65:0] act,
                       input logic [65:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vt[8];

    // Reference: {cout, ovf, sum} at width w from a w+1-bit sum
    function automatic logic [65:0] ref_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic ci,
                                            input int w);
        logic [64:0] full;
        logic [63:0] m;
        logic sa, sb, ss, co;
        m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        full = {1'b0, a & m} + {1'b0, b & m} + {64'd0, ci};
        co   = full[w];
        sa   = a[w-1];
        sb   = b[w-1];
        ss   = full[w-1];
        return {co, (sa == sb) && (ss != sa), full[63:0] & m};
    endfunction

    logic [65:0] e8, e32, e64, p8, p32, p64;

    initial begin
        vt[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0, 1'b0};
        vt[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vt[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vt[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vt[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vt[5] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0};
        vt[6] = '{32'h0F0F0F0F, 32'h00F0F0F0, 1'b1, 32'h10000000, 1'b0, 1'b0};
        vt[7] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};

        rst = 1'b1;
        a32 = 32'd5; b32 = 32'd3; c32 = 1'b0;
        a8 = '0; b8 = '0; c8 = 1'b0;
        a64 = '0; b64 = '0; c64 = 1'b0;

        // Reset state and combinational tracking under reset
        @(posedge clk); #1;
        chk("rst_q32", {coq32, ovq32, sq32}, '0);
        chk("rst_q8", {coq8, ovq8, sq8}, '0);
        chk("rst_q64", {coq64, ovq64, sq64}, '0);
        chk("rst_comb32", {co32, ov32, s32}, {2'b00, 32'h8});
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a32 = vt[i].a; b32 = vt[i].b; c32 = vt[i].ci;
            #1;
            chk($sformatf("comb[%0d]", i), {co32, ov32, s32},
                {vt[i].co, vt[i].ov, vt[i].s});
            @(posedge clk); #1;
            chk($sformatf("reg[%0d]", i), {coq32, ovq32, sq32},
                {vt[i].co, vt[i].ov, vt[i].s});
            chk($sformatf("noreg[%0d]", i), {coz, ovz, sz}, '0);
        end

        // Reset between edges clears the held result immediately
        @(negedge clk);
        a32 = 32'd5; b32 = 32'd3; c32 = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_q", {34'd0, sq32}, 66'h8);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_q", {coq32, ovq32, sq32}, '0);
        chk("mid_rst_sal", {34'd0, s32}, 66'h8);
        @(posedge clk); #1;
        chk("held_rst_q", {coq32, ovq32, sq32}, '0);
        a32 = 32'd1; b32 = 32'd1;
        #1;
        chk("rst_track", {34'd0, s32}, 66'h2);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_load", {coq32, ovq32, sq32}, {2'b00, 32'h2});

        // Random sweep, all three widths every cycle
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("rnd_q8", {56'd0, coq8, ovq8, sq8}, p8);
                chk("rnd_q32", {32'd0, coq32, ovq32, sq32}, p32);
                chk("rnd_q64", {coq64, ovq64, sq64}, p64);
            end
            a8  = 8'($urandom);  b8  = 8'($urandom);  c8  = 1'($urandom);
            a32 = $urandom;      b32 = $urandom;      c32 = 1'($urandom);
            a64 = {$urandom, $urandom};
            b64 = {$urandom, $urandom};
            c64 = 1'($urandom);
            if (i % 16 == 0) begin
                a64 = '1;
                b64 = 64'd0;
                c64 = 1'b1;
            end
            e8  = ref_add({56'd0, a8}, {56'd0, b8}, c8, 8);
            e32 = ref_add({32'd0, a32}, {32'd0, b32}, c32, 32);
            e64 = ref_add(a64, b64, c64, 64);
            #1;
            chk("rnd_c8", {56'd0, co8, ov8, s8},
                {56'd0, e8[65:64], e8[7:0]});
            chk("rnd_c32", {32'd0, co32, ov32, s32},
                {32'd0, e32[65:64], e32[31:0]});
            chk("rnd_c64", {co64, ov64, s64}, e64);
            p8  = {56'd0, e8[65:64], e8[7:0]};
            p32 = {32'd0, e32[65:64], e32[31:0]};
            p64 = e64;
        end
        @(negedge clk);
        chk("rnd_last_q64", {coq64, ovq64, sq64}, p64);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
